swalloc_seq: RTL and testbench

//  Two-stage pipelined scheduler wrapped around the 4-rank sequential port allocator of the BLESS router.

---
 rtl/swalloc_seq.sv | 173 +++++++++++++++++
 tb/tb_swalloc_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/swalloc_seq.sv
// Two-stage BLESS port scheduler: stage 1 merges a local injection and ranks slots oldest-first,
// stage 2 runs greedy rank-ordered port allocation with deflection and keeps deflection statistics.
`timescale 1ns/1ps
module swalloc_seq #(
    parameter int AGE_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           in_valid,
    input  logic [4*AGE_W-1:0]   in_age,
    input  logic [15:0]          in_ppv,
    input  logic                 inj_req,
    input  logic [3:0]           inj_ppv,
    output logic                 inj_gnt,
    input  logic                 stat_clr,
    output logic [3:0]           out_valid,
    output logic [7:0]           out_sel,
    output logic [4*AGE_W-1:0]   out_age,
    output logic [3:0]           out_defl,
    output logic [CNT_W-1:0]     defl_cnt
);

    function automatic logic [3:0] lowbit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    function automatic logic [AGE_W-1:0] sat_inc_age(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + AGE_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] c, input logic [2:0] n);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W+1)'(n);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Slot t outranks slot s: valid first, then older, then lower index.
    function automatic logic beats(input logic v_t, input logic v_s,
                                   input logic [AGE_W-1:0] a_t, input logic [AGE_W-1:0] a_s,
                                   input int t, input int s);
        if (v_t != v_s) return v_t;
        if (!v_t)       return t < s;
        if (a_t != a_s) return a_t > a_s;
        return t < s;
    endfunction

    logic [3:0]           vld_p1_d, vld_p1_q;
    logic [4*AGE_W-1:0]   age_p1_d, age_p1_q;
    logic [15:0]          ppv_p1_d, ppv_p1_q;
    logic [7:0]           ord_p1_d, ord_p1_q;

    logic [3:0]           out_valid_d, out_valid_q;
    logic [7:0]           out_sel_d, out_sel_q;
    logic [4*AGE_W-1:0]   out_age_d, out_age_q;
    logic [3:0]           out_defl_d, out_defl_q;
    logic [CNT_W-1:0]     defl_cnt_d, defl_cnt_q;

    logic [3:0]           free_oh;
    int                   rank_cnt;
    logic [3:0]           avail, cand, gnt;
    logic                 dfl;
    int                   slot;

    // Stage 0: injection merge and oldest-first ranking (ord holds slot id per rank)
    always_comb begin
        free_oh  = lowbit(~in_valid);
        inj_gnt  = inj_req & ~(&in_valid) & ~reset;
        vld_p1_d = in_valid;
        age_p1_d = in_age;
        ppv_p1_d = in_ppv;
        for (int s = 0; s < 4; s++) begin
            if (inj_gnt && free_oh[s]) begin
                vld_p1_d[s]                = 1'b1;
                age_p1_d[s*AGE_W +: AGE_W] = '0;
                ppv_p1_d[s*4 +: 4]         = inj_ppv;
            end
        end
        ord_p1_d = '0;
        rank_cnt = 0;
        for (int s = 0; s < 4; s++) begin
            rank_cnt = 0;
            for (int t = 0; t < 4; t++) begin
                if (t != s && beats(vld_p1_d[t], vld_p1_d[s],
                                    age_p1_d[t*AGE_W +: AGE_W], age_p1_d[s*AGE_W +: AGE_W], t, s))
                    rank_cnt = rank_cnt + 1;
            end
            ord_p1_d[rank_cnt*2 +: 2] = 2'(s);
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q <= '0;
            age_p1_q <= '0;
            ppv_p1_q <= '0;
            ord_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            age_p1_q <= age_p1_d;
            ppv_p1_q <= ppv_p1_d;
            ord_p1_q <= ord_p1_d;
        end
    end

    // Stage 1 -> 2: greedy allocation in rank order; at most 4 flits so avail never runs dry
    always_comb begin
        avail       = 4'hF;
        cand        = '0;
        gnt         = '0;
        dfl         = 1'b0;
        slot        = 0;
        out_valid_d = '0;
        out_sel_d   = '0;
        out_age_d   = '0;
        out_defl_d  = '0;
        for (int r = 0; r < 4; r++) begin
            slot = int'(ord_p1_q[r*2 +: 2]);
            if (vld_p1_q[slot]) begin
                cand = ppv_p1_q[slot*4 +: 4] & avail;
                if (cand != '0) begin
                    gnt = lowbit(cand);
                    dfl = 1'b0;
                end else begin
                    gnt = lowbit(avail);
                    dfl = 1'b1;
                end
                avail = avail & ~gnt;
                for (int p = 0; p < 4; p++) begin
                    if (gnt[p]) begin
                        out_valid_d[p]             = 1'b1;
                        out_sel_d[p*2 +: 2]        = ord_p1_q[r*2 +: 2];
                        out_age_d[p*AGE_W +: AGE_W] = sat_inc_age(age_p1_q[slot*AGE_W +: AGE_W]);
                        out_defl_d[p]              = dfl;
                    end
                end
            end
        end
        defl_cnt_d = stat_clr ? '0 : sat_add_cnt(defl_cnt_q, popcount4(out_defl_d));
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= '0;
            out_sel_q   <= '0;
            out_age_q   <= '0;
            out_defl_q  <= '0;
            defl_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_age_q   <= out_age_d;
            out_defl_q  <= out_defl_d;
            defl_cnt_q  <= defl_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign out_age   = out_age_q;
    assign out_defl  = out_defl_q;
    assign defl_cnt  = defl_cnt_q;

endmodule

// File: tb/tb_swalloc_seq.sv
// Randomized and directed bench for swalloc_seq against a sort-and-allocate reference model.
`timescale 1ns/1ps
module tb_swalloc_seq;
    localparam int AGE_W = 8;
    localparam int CNT_W = 16;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         in_valid;
    logic [4*AGE_W-1:0] in_age;
    logic [15:0]        in_ppv;
    logic               inj_req;
    logic [3:0]         inj_ppv;
    logic               inj_gnt;
    logic               stat_clr;
    logic [3:0]         out_valid;
    logic [7:0]         out_sel;
    logic [4*AGE_W-1:0] out_age;
    logic [3:0]         out_defl;
    logic [CNT_W-1:0]   defl_cnt;

    swalloc_seq #(.AGE_W(AGE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_age(in_age), .in_ppv(in_ppv),
        .inj_req(inj_req), .inj_ppv(inj_ppv), .inj_gnt(inj_gnt), .stat_clr(stat_clr),
        .out_valid(out_valid), .out_sel(out_sel), .out_age(out_age), .out_defl(out_defl),
        .defl_cnt(defl_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: batch held in stage 1 and the expected stage-2 outputs.
    logic [3:0] m_vld;
    int         m_age [4];
    logic [3:0] m_ppv [4];
    logic [3:0] e_valid, e_defl;
    int         e_sel [4];
    int         e_age [4];
    longint     e_cnt;

    function automatic logic exp_gnt();
        return inj_req && (in_valid != 4'hF);
    endfunction

    task automatic model_clear();
        m_vld = '0; e_valid = '0; e_defl = '0; e_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_age[i] = 0; m_ppv[i] = '0; e_sel[i] = 0; e_age[i] = 0;
        end
    endtask

    task automatic model_edge();
        int order[$];
        logic [3:0] avail;
        int ndefl, p, d, s, tmp;
        avail = 4'hF; ndefl = 0; e_valid = '0; e_defl = '0;
        for (int i = 0; i < 4; i++) begin e_sel[i] = 0; e_age[i] = 0; end
        for (int i = 0; i < 4; i++) if (m_vld[i]) order.push_back(i);
        for (int i = 0; i < order.size(); i++)
            for (int j = i + 1; j < order.size(); j++)
                if (m_age[order[j]] > m_age[order[i]] ||
                    (m_age[order[j]] == m_age[order[i]] && order[j] < order[i])) begin
                    tmp = order[i]; order[i] = order[j]; order[j] = tmp;
                end
        foreach (order[k]) begin
            s = order[k]; p = -1; d = 0;
            for (int q = 0; q < 4; q++) if (p < 0 && m_ppv[s][q] && avail[q]) p = q;
            if (p < 0) begin
                d = 1;
                for (int q = 0; q < 4; q++) if (p < 0 && avail[q]) p = q;
            end
            avail[p] = 1'b0; e_valid[p] = 1'b1; e_sel[p] = s;
            e_age[p] = (m_age[s] + 1 > 255) ? 255 : m_age[s] + 1;
            e_defl[p] = d[0]; ndefl += d;
        end
        if (stat_clr) e_cnt = 0;
        else          e_cnt = (e_cnt + ndefl > CNT_MAX) ? CNT_MAX : e_cnt + ndefl;
        m_vld = in_valid;
        for (int i = 0; i < 4; i++) begin
            m_age[i] = int'(in_age[i*AGE_W +: AGE_W]);
            m_ppv[i] = in_ppv[i*4 +: 4];
        end
        if (exp_gnt()) begin
            p = -1;
            for (int q = 0; q < 4; q++) if (p < 0 && !in_valid[q]) p = q;
            m_vld[p] = 1'b1; m_age[p] = 0; m_ppv[p] = inj_ppv;
        end
    endtask

    task automatic check_outputs();
        logic [7:0]  es;
        logic [31:0] ea;
        for (int p = 0; p < 4; p++) begin
            es[p*2 +: 2] = 2'(e_sel[p]);
            ea[p*8 +: 8] = 8'(e_age[p]);
        end
        check_eq("out_valid", 64'(out_valid), 64'(e_valid));
        check_eq("out_sel",   64'(out_sel),   64'(es));
        check_eq("out_age",   64'(out_age),   64'(ea));
        check_eq("out_defl",  64'(out_defl),  64'(e_defl));
        check_eq("defl_cnt",  64'(defl_cnt),  64'(e_cnt));
    endtask

    // Called right after a negedge with inputs already driven.
    task automatic tick();
        #1;
        check_eq("inj_gnt", 64'(inj_gnt), 64'(exp_gnt()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        in_valid = '0; in_age = '0; in_ppv = '0; inj_req = 1'b0; inj_ppv = '0; stat_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; inj_req = 1'b1; stat_clr = 1'b0;
        #1;
        check_eq("rst_inj_gnt",   64'(inj_gnt),   64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_defl_cnt",  64'(defl_cnt),  64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle();
    endtask

    task automatic drive_defl(input int k);
        in_valid = 4'((1 << k) - 1);
        in_ppv   = '0;
        in_age   = {$urandom, $urandom} >> 32;
        inj_req  = 1'b0;
        stat_clr = 1'b0;
    endtask

    initial begin
        longint rem;
        int k;
        idle();
        do_reset();

        // Idle after reset
        repeat (10) tick();
        check_eq("t1_out_valid", 64'(out_valid), 64'd0);
        check_eq("t1_defl_cnt",  64'(defl_cnt),  64'd0);

        // Ages 5/9/9/1, all want port 0
        in_valid = 4'hF; in_age = {8'd1, 8'd9, 8'd9, 8'd5}; in_ppv = 16'h1111;
        tick(); idle(); tick();
        check_eq("t2_out_sel",  64'(out_sel),      64'b11_00_10_01);
        check_eq("t2_out_defl", 64'(out_defl),     64'b1110);
        check_eq("t2_defl_cnt", 64'(defl_cnt),     64'd3);
        check_eq("t2_age0",     64'(out_age[7:0]), 64'd10);

        // Injection into slot 2
        in_valid = 4'b1011; in_age = {8'd5, 8'd0, 8'd4, 8'd3}; in_ppv = 16'h8021;
        inj_req = 1'b1; inj_ppv = 4'b0100;
        #1 check_eq("t3_inj_gnt", 64'(inj_gnt), 64'd1);
        tick(); idle(); tick();
        check_eq("t3_out_sel",  64'(out_sel),        64'hE4);
        check_eq("t3_out_defl", 64'(out_defl),       64'd0);
        check_eq("t3_age2",     64'(out_age[23:16]), 64'd1);

        // Injection held while all slots busy
        in_valid = 4'hF; in_age = {8'd7, 8'd6, 8'd5, 8'd4}; in_ppv = 16'h8421;
        inj_req = 1'b1; inj_ppv = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("t4_held", 64'(inj_gnt), 64'd0);
            tick();
        end
        in_valid = 4'b1101;
        #1 check_eq("t4_gnt", 64'(inj_gnt), 64'd1);
        tick(); idle(); tick(); tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 4'($urandom);
            for (int s = 0; s < 4; s++)
                in_age[s*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            in_ppv   = 16'($urandom);
            inj_req  = 1'($urandom);
            inj_ppv  = 4'($urandom);
            stat_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle(); tick(); tick();

        // Counter saturation
        do_reset();
        while (e_cnt < CNT_MAX - 9) begin drive_defl(4); tick(); end
        idle(); tick(); tick();
        rem = CNT_MAX - 1 - e_cnt;
        while (rem > 0) begin
            k = (rem > 4) ? 4 : int'(rem);
            drive_defl(k); tick(); rem -= k;
        end
        idle(); tick(); tick();
        check_eq("t5_cnt_max_m1", 64'(defl_cnt), CNT_MAX - 1);
        drive_defl(4); tick(); idle(); tick();
        check_eq("t5_cnt_sat", 64'(defl_cnt), CNT_MAX);
        drive_defl(4); tick(); idle(); tick();
        check_eq("t5_cnt_hold", 64'(defl_cnt), CNT_MAX);
        in_valid = 4'b0001; in_age = 32'h0000_00FF; in_ppv = 16'h0001;
        tick(); idle(); tick();
        check_eq("t5_age_sat", 64'(out_age[7:0]), 64'hFF);
        drive_defl(4); tick(); idle(); stat_clr = 1'b1; tick();
        check_eq("t5_clr_prio", 64'(defl_cnt), 64'd0);
        check_eq("t5_clr_defl", 64'(out_defl), 64'hF);
        idle(); tick();

        // Reset between stage 1 and stage 2
        in_valid = 4'hF; in_age = {8'd4, 8'd3, 8'd2, 8'd1}; in_ppv = 16'h1248;
        tick();
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_no_pulse", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
